// File: rtl/bsg_chip_link_reset_sequencer.sv
// bsg_chip_link_reset_sequencer
// Runs the bring-up reset sequence for the chip's bsg_link channels after a
// start request: token reset pulse, upstream release, downstream release,
// core release. Each phase lasts latched_wait+1 cycles.
//
// Optional feature: define BSG_CHIP_LINK_RESET_SEQUENCER_ABORT_EN to add
// abort_i, which restarts a running sequence from ASSERT_ALL.
//
// state      | meaning
// -----------+------------------------------------------------------------
// IDLE       | waiting for start; all links held in reset
// ASSERT_ALL | all enabled links held in reset, token reset low
// TOKEN_HI   | async token reset pulse high on enabled links
// TOKEN_LO   | token pulse finished, links still in reset
// UP_REL     | upstream (tx) link reset released
// DOWN_REL   | downstream (rx) link reset released
// CORE_REL   | core reset released
// DONE       | sequence complete; waits for a restart

module bsg_chip_link_reset_sequencer #(
    parameter int num_links_p  = 16,
    parameter int wait_width_p = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [wait_width_p-1:0] wait_cycles_i,
    input  logic [num_links_p-1:0]  link_en_i,
`ifdef BSG_CHIP_LINK_RESET_SEQUENCER_ABORT_EN
    input  logic                    abort_i,
`endif
    output logic [num_links_p-1:0]  up_link_reset_o,
    output logic [num_links_p-1:0]  down_link_reset_o,
    output logic [num_links_p-1:0]  async_token_reset_o,
    output logic [num_links_p-1:0]  core_reset_o,
    output logic                    busy_o,
    output logic                    done_o
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ASSERT_ALL = 3'd1,
        TOKEN_HI   = 3'd2,
        TOKEN_LO   = 3'd3,
        UP_REL     = 3'd4,
        DOWN_REL   = 3'd5,
        CORE_REL   = 3'd6,
        DONE       = 3'd7
    } state_e;

    state_e                  state_r, state_n;
    logic [wait_width_p-1:0] wait_r, wait_n;
    logic [num_links_p-1:0]  mask_r, mask_n;
    // One bit wider than the wait so a full 2^wait_width_p phase never wraps.
    logic [wait_width_p:0]   cnt_r, cnt_n;

    logic                    busy_state;
    logic                    phase_end;

    logic [num_links_p-1:0]  up_n, down_n, token_n, core_n;
    logic                    busy_n, done_n;

    assign busy_state = (state_r != IDLE) && (state_r != DONE);
    assign phase_end  = (cnt_r == {1'b0, wait_r});

    // Next-state, latched configuration and phase counter.
    always_comb begin
        state_n = state_r;
        wait_n  = wait_r;
        mask_n  = mask_r;
        cnt_n   = cnt_r;
        case (state_r)
            IDLE, DONE: begin
                if (start_i) begin
                    state_n = ASSERT_ALL;
                    wait_n  = wait_cycles_i;
                    mask_n  = link_en_i;
                    cnt_n   = '0;
                end
            end
            default: begin
                if (phase_end) begin
                    cnt_n = '0;
                    case (state_r)
                        ASSERT_ALL: state_n = TOKEN_HI;
                        TOKEN_HI:   state_n = TOKEN_LO;
                        TOKEN_LO:   state_n = UP_REL;
                        UP_REL:     state_n = DOWN_REL;
                        DOWN_REL:   state_n = CORE_REL;
                        CORE_REL:   state_n = DONE;
                        default:    state_n = IDLE;
                    endcase
                end else begin
                    cnt_n = cnt_r + (wait_width_p+1)'(1);
                end
            end
        endcase
`ifdef BSG_CHIP_LINK_RESET_SEQUENCER_ABORT_EN
        // Abort beats phase advance; mask and wait are kept for the rerun.
        if (abort_i && busy_state) begin
            state_n = ASSERT_ALL;
            cnt_n   = '0;
        end
`endif
    end

    // Output decode from the next state so the outputs can be registered.
    always_comb begin
        up_n    = '1;
        down_n  = '1;
        token_n = '0;
        core_n  = '1;
        case (state_n)
            TOKEN_HI: token_n = mask_n;
            UP_REL:   up_n    = ~mask_n;
            DOWN_REL: begin
                up_n   = ~mask_n;
                down_n = ~mask_n;
            end
            CORE_REL, DONE: begin
                up_n   = ~mask_n;
                down_n = ~mask_n;
                core_n = ~mask_n;
            end
            default: ;
        endcase
        busy_n = (state_n != IDLE) && (state_n != DONE);
        done_n = (state_n == DONE);
    end

    // State, configuration, counter and registered outputs; reset truncates any token pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r             <= IDLE;
            wait_r              <= '0;
            mask_r              <= '0;
            cnt_r               <= '0;
            up_link_reset_o     <= '1;
            down_link_reset_o   <= '1;
            async_token_reset_o <= '0;
            core_reset_o        <= '1;
            busy_o              <= 1'b0;
            done_o              <= 1'b0;
        end else begin
            state_r             <= state_n;
            wait_r              <= wait_n;
            mask_r              <= mask_n;
            cnt_r               <= cnt_n;
            up_link_reset_o     <= up_n;
            down_link_reset_o   <= down_n;
            async_token_reset_o <= token_n;
            core_reset_o        <= core_n;
            busy_o              <= busy_n;
            done_o              <= done_n;
        end
    end

endmodule
